// File: rtl/logic_unit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter_pkg
// Shared definitions for the logic-unit arbiter: opcode encodings understood
// by the shared bitwise logic unit, and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // waiting for a request, grant search active
    ST_EXEC = 2'b01,  // shared logic unit evaluates the captured operands
    ST_RESP = 2'b10   // result presented until the downstream accepts it
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// -----------------------------------------------------------------------------
// logic_unit
// Purely combinational bitwise two-input unit shared by all requesters.
// Ports:
//   op_i  opcode (AND/OR/XOR/NOR, encodings from logic_unit_arbiter_pkg)
//   a_i   operand A, WIDTH bits
//   b_i   operand B, WIDTH bits
//   y_o   bitwise result, WIDTH bits, no carry between bit positions
// -----------------------------------------------------------------------------
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
// Round-robin scheduler that lets NREQ requesters share one bitwise logic
// unit. A request is accepted in IDLE, evaluated in EXEC and returned in RESP,
// tagged with the requester index.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   per-requester handshake (req_ready one-hot or 0)
//   req_op / req_a / req_b  per-requester payload, slice i per requester
//   rsp_valid / rsp_ready   response handshake
//   rsp_data / rsp_id       result and owning requester index
//   busy                    high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q,   ptr_d;
  logic [IDW-1:0]   id_q,    id_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] data_q,  data_d;

  logic             found;
  logic [IDW-1:0]   gnt;
  logic [WIDTH-1:0] lu_y;

  // Round-robin search: walk the request vector starting at ptr_q. NREQ is a
  // power of two, so the IDW-bit sum wraps around naturally.
  always_comb begin
    found = 1'b0;
    gnt   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      logic [IDW-1:0] idx;
      idx = ptr_q + IDW'(i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (lu_y)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gates the grant so req_ready stays low while reset is held,
        // even though the reset state is IDLE.
        if (rst_n && found) begin
          req_ready[gnt] = 1'b1;
          op_d           = req_op[2*int'(gnt) +: 2];
          a_d            = req_a[WIDTH*int'(gnt) +: WIDTH];
          b_d            = req_b[WIDTH*int'(gnt) +: WIDTH];
          id_d           = gnt;
          ptr_d          = gnt + IDW'(1);
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = lu_y;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset too, because rsp_data and rsp_id
      // are driven straight from them and must read 0 out of reset.
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  logic [1:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  int passed = 0;
  int total  = 0;
  int model_ptr = 0;
  int last_gnt;
  logic [WIDTH-1:0] last_data;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_op[2*i +: 2]         = op_arr[i];
      req_a[WIDTH*i +: WIDTH]  = a_arr[i];
      req_b[WIDTH*i +: WIDTH]  = b_arr[i];
    end
  end

  logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Reference: the winner is the valid requester at the smallest circular
  // distance forward from the pointer.
  function automatic int model_grant(input logic [NREQ-1:0] v);
    int best = -1;
    int best_dist = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        int d;
        d = (i - model_ptr + NREQ) % NREQ;
        if (d < best_dist) begin
          best_dist = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [WIDTH-1:0] model_result(input logic [1:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // One full transaction from an IDLE cycle with requests already driven.
  // Entered shortly after a falling edge; returns at the same phase in IDLE.
  task automatic serve(input int hold, input bit keep);
    int g;
    logic [NREQ-1:0]  exp_rdy;
    logic [WIDTH-1:0] exp_d;
    #1;
    g = model_grant(req_valid);
    total++;
    if (g < 0) begin
      $display("FAIL serve_setup: no valid request, req_valid=%b", req_valid);
      return;
    end
    passed++;
    exp_rdy = NREQ'(1) << g;
    exp_d   = model_result(op_arr[g], a_arr[g], b_arr[g]);
    total++;
    if (req_ready !== exp_rdy || busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL grant: req_ready=%b busy=%b rsp_valid=%b expected %b/0/0",
               req_ready, busy, rsp_valid, exp_rdy);
    else passed++;
    model_ptr = (g + 1) % NREQ;
    last_gnt  = g;

    @(negedge clk);
    if (!keep) req_valid[g] = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b1)
      $display("FAIL exec: rsp_valid=%b req_ready=%b busy=%b expected 0/0000/1",
               rsp_valid, req_ready, busy);
    else passed++;

    @(negedge clk);
    if (hold > 0) rsp_ready = 1'b0;
    #1;
    last_data = rsp_data;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== IDW'(g) || req_ready !== '0)
      $display("FAIL resp: valid=%b data=%h id=%0d ready=%b expected 1/%h/%0d/0000",
               rsp_valid, rsp_data, rsp_id, req_ready, exp_d, g);
    else passed++;

    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== IDW'(g) || req_ready !== '0)
        $display("FAIL hold: cycle %0d valid=%b data=%h id=%0d ready=%b expected 1/%h/%0d/0000",
                 k, rsp_valid, rsp_data, rsp_id, req_ready, exp_d, g);
      else passed++;
    end
    rsp_ready = 1'b1;

    @(negedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL back_to_idle: rsp_valid=%b busy=%b expected 0/0", rsp_valid, busy);
    else passed++;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < cycles; k++) begin
      total++;
      if ({req_ready, rsp_valid, rsp_data, rsp_id, busy} !== '0)
        $display("FAIL in_reset: ready=%b valid=%b data=%h id=%0d busy=%b expected all 0",
                 req_ready, rsp_valid, rsp_data, rsp_id, busy);
      else passed++;
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    do_reset(3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      total++;
      if ({req_ready, rsp_valid, rsp_data, rsp_id, busy} !== '0)
        $display("FAIL idle: ready=%b valid=%b data=%h id=%0d busy=%b expected all 0",
                 req_ready, rsp_valid, rsp_data, rsp_id, busy);
      else passed++;
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_single();
    op_arr[0] = 2'b01; a_arr[0] = 8'hA0; b_arr[0] = 8'h0F;
    req_valid = 4'b0001;
    serve(0, 1'b0);
    total++;
    if (last_gnt != 0 || last_data !== 8'hAF)
      $display("FAIL single: id=%0d data=%h expected 0/af", last_gnt, last_data);
    else passed++;
  endtask

  task automatic test_all_four();
    int exp_id [4] = '{0, 1, 2, 3};
    logic [WIDTH-1:0] exp_data [4] = '{8'h88, 8'hEE, 8'h66, 8'h11};
    do_reset(1);
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = 2'(i);
      a_arr[i]  = 8'hCC;
      b_arr[i]  = 8'hAA;
    end
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      serve(0, 1'b0);
      total++;
      if (last_gnt != exp_id[i] || last_data !== exp_data[i])
        $display("FAIL all_four: step %0d id=%0d data=%h expected %0d/%h",
                 i, last_gnt, last_data, exp_id[i], exp_data[i]);
      else passed++;
    end
    req_valid = 4'b0001;
    serve(0, 1'b0);
    total++;
    if (last_gnt != 0) $display("FAIL all_four_regrant: id=%0d expected 0", last_gnt);
    else passed++;
  endtask

  task automatic test_backpressure();
    op_arr[2] = 2'b10; a_arr[2] = 8'h5A; b_arr[2] = 8'hFF;
    op_arr[3] = 2'b11; a_arr[3] = 8'h12; b_arr[3] = 8'h34;
    req_valid = 4'b1100;
    serve(5, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_mid_reset();
    op_arr[1] = 2'b00; a_arr[1] = 8'hF0; b_arr[1] = 8'h3C;
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010) $display("FAIL mid_reset_grant: req_ready=%b expected 0010", req_ready);
    else passed++;
    @(negedge clk);
    req_valid = 4'b0101;
    op_arr[0] = 2'b01; a_arr[0] = 8'h01; b_arr[0] = 8'h02;
    op_arr[2] = 2'b10; a_arr[2] = 8'h0F; b_arr[2] = 8'hFF;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({req_ready, rsp_valid, busy} !== '0)
        $display("FAIL mid_reset_hold: ready=%b valid=%b busy=%b expected 0", req_ready, rsp_valid, busy);
      else passed++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_ptr = 0;
    serve(0, 1'b0);
    total++;
    if (last_gnt != 0) $display("FAIL mid_reset_ptr: first grant=%0d expected 0", last_gnt);
    else passed++;
    serve(0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_fairness();
    int exp_seq [4] = '{3, 1, 3, 1};
    req_valid = 4'b0010;
    serve(0, 1'b0);
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      serve(0, 1'b1);
      total++;
      if (last_gnt != exp_seq[i])
        $display("FAIL fairness: step %0d grant=%0d expected %0d", i, last_gnt, exp_seq[i]);
      else passed++;
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_arr[i] = 2'($urandom_range(0, 3));
        a_arr[i]  = WIDTH'($urandom);
        b_arr[i]  = WIDTH'($urandom);
      end
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      serve(int'($urandom_range(0, 2)), 1'b0);
      req_valid = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = '0;
      a_arr[i]  = '0;
      b_arr[i]  = '0;
    end
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_mid_reset();
    test_fairness();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
